multicycle_control: RTL and testbench

//  Multi-cycle main control FSM for the piRISC core. Sequences fetch, decode, execute, memory and writeback.

---
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the multi-cycle piRISC core. It sequences each
//   instruction through FETCH, DECODE, EXEC or MEM(+WB), steers the ALU operand
//   muxes, and runs the imem/dmem req/ack handshakes.
//
//   Selects and requests depend only on the current state. The ir_we, pc_we
//   and rf_we strobes, and the internal retire pulse, are additionally
//   qualified by the acks (Mealy). A reset therefore drops any pending request
//   immediately, without waiting for a clock edge.
//
//   Configuration macro: INSTRET_CNT_EN
//     defined   : instret counts retired instructions (wraps mod 2^XLEN)
//     undefined : no counter flops, instret tied to 0 (FSM timing unchanged)
//
// Parameters
//   XLEN       width of the instret counter
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   opcode     IR[6:0]
//   imem_ack   instruction word valid (sampled at posedge)
//   dmem_ack   data access complete (sampled at posedge)
//   imem_req   instruction fetch request
//   dmem_req   data access request
//   dmem_we    1=store, 0=load (valid with dmem_req)
//   ir_we      IR load strobe
//   pc_we      PC load strobe (PC <= ALU result)
//   rf_we      register-file write strobe
//   alu_src_a  0=PC, 1=rs1
//   alu_src_b  00=rs2, 01=imm, 10=const 4
//   alu_op_en  1=ALU uses decoded aluop, 0=ALU forced to ADD
//   wb_sel     0=ALU result, 1=MDR
//   illegal    sticky unsupported-opcode flag
//   state      current FSM state (debug)
//   instret    retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            ir_we,
    output logic            pc_we,
    output logic            rf_we,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            alu_op_en,
    output logic            wb_sel,
    output logic            illegal,
    output logic [2:0]      state,
    output logic [XLEN-1:0] instret
);

    localparam logic [6:0] OP_RTYPE    = 7'b0110011;
    localparam logic [6:0] OP_ITYPE    = 7'b0010011;
    localparam logic [6:0] OP_LOADTYPE = 7'b0000011;
    localparam logic [6:0] OP_STYPE    = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t state_q;

    logic is_store;
    logic is_itype;

    assign is_store = (opcode == OP_STYPE);
    assign is_itype = (opcode == OP_ITYPE);
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_q <= S_FETCH;
                S_FETCH:  if (imem_ack) state_q <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE, OP_ITYPE:    state_q <= S_EXEC;
                        OP_LOADTYPE, OP_STYPE: state_q <= S_MEM;
                        default:               state_q <= S_TRAP;
                    endcase
                end
                S_EXEC:   state_q <= S_FETCH;
                S_MEM:    if (dmem_ack) state_q <= is_store ? S_FETCH : S_WB;
                S_WB:     state_q <= S_FETCH;
                S_TRAP:   state_q <= S_TRAP;
                // Encoding 7 is never entered; fall back to a clean restart.
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op_en = 1'b0;
        wb_sel    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // ALU computes PC+4 while the fetch is outstanding.
                imem_req  = 1'b1;
                alu_src_b = 2'b10;
                ir_we     = imem_ack;
                pc_we     = imem_ack;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = is_itype ? 2'b01 : 2'b00;
                alu_op_en = 1'b1;
                rf_we     = 1'b1;
            end
            S_MEM: begin
                // Address rs1+imm stays on the ALU for the whole access.
                alu_src_a = 1'b1;
                alu_src_b = 2'b01;
                dmem_req  = 1'b1;
                dmem_we   = is_store;
            end
            S_WB: begin
                rf_we     = 1'b1;
                wb_sel    = 1'b1;
            end
            S_TRAP: begin
                // TRAP only exits through reset, so the flag is sticky.
                illegal   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef INSTRET_CNT_EN
    logic            retire;
    logic [XLEN-1:0] instret_q;

    assign retire = (state_q == S_EXEC) || (state_q == S_WB) ||
                    ((state_q == S_MEM) && dmem_ack && is_store);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + XLEN'(1);
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

`ifdef INSTRET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        imem_ack, dmem_ack;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic        alu_src_a, alu_op_en, wb_sel, illegal;
    logic [1:0]  alu_src_b;
    logic [2:0]  state;
    logic [31:0] instret;

    multicycle_control #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_en(alu_op_en),
        .wb_sel(wb_sel), .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // Expected per-cycle output bundle; field order matches 'act' below.
    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, src_a;
        logic [1:0] src_b;
        logic       op_en, wb_sel, illegal;
    } exp_t;

    exp_t        exp_q;
    logic [14:0] act;
    logic [31:0] exp_cnt;
    logic [31:0] cnt;          // model retire count
    bit          chk_en = 1'b0;
    int          nchk = 0;
    int          nerr = 0;
    int          dreq_cycles = 0;
    logic        iack_bg, dack_bg; // ack levels driven while the matching req is low

    assign act = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
                  alu_src_a, alu_src_b, alu_op_en, wb_sel, illegal};

    always @(negedge clk) begin
        if (chk_en) begin
            nchk++;
            if (act !== exp_q) begin
                nerr++;
                $display("FAIL ctrl t=%0t state=%0d/%0d got=%b want=%b",
                         $time, state, exp_q.st, act, exp_q);
            end
            nchk++;
            if (instret !== (CNT_EN ? exp_cnt : 32'd0)) begin
                nerr++;
                $display("FAIL instret t=%0t got=%0d want=%0d",
                         $time, instret, CNT_EN ? exp_cnt : 32'd0);
            end
            if (dmem_req) dreq_cycles++;
        end
    end

    function automatic exp_t z(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    task automatic cyc(input logic ia, input logic da, input exp_t e);
        imem_ack = ia;
        dmem_ack = da;
        exp_q    = e;
        exp_cnt  = cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cnt   = '0;
        cyc(iack_bg, dack_bg, z(3'd0));
        cyc(iack_bg, dack_bg, z(3'd0));
        rst_n = 1'b1;
        cyc(iack_bg, dack_bg, z(3'd0));   // one IDLE cycle after release
    endtask

    // One instruction: iw wait cycles before imem_ack, dw before dmem_ack.
    // abort_k >= 0 leaves the MEM phase before its k-th cycle (caller resets).
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                             input int abort_k);
        exp_t e;
        opcode = op;
        for (int k = 0; k <= iw; k++) begin
            e = z(3'd1);
            e.imem_req = 1'b1;
            e.src_b    = 2'b10;
            e.ir_we    = (k == iw);
            e.pc_we    = (k == iw);
            cyc(k == iw, dack_bg, e);
        end
        cyc(iack_bg, dack_bg, z(3'd2));
        if (op == OP_R || op == OP_I) begin
            e = z(3'd3);
            e.src_a = 1'b1;
            e.op_en = 1'b1;
            e.src_b = (op == OP_I) ? 2'b01 : 2'b00;
            e.rf_we = 1'b1;
            cyc(iack_bg, dack_bg, e);
            cnt++;
        end else if (op == OP_L || op == OP_S) begin
            for (int k = 0; k <= dw; k++) begin
                if (k == abort_k) return;
                e = z(3'd4);
                e.src_a    = 1'b1;
                e.src_b    = 2'b01;
                e.dmem_req = 1'b1;
                e.dmem_we  = (op == OP_S);
                cyc(iack_bg, k == dw, e);
            end
            if (op == OP_S) begin
                cnt++;
            end else begin
                e = z(3'd5);
                e.rf_we  = 1'b1;
                e.wb_sel = 1'b1;
                cyc(iack_bg, dack_bg, e);
                cnt++;
            end
        end else begin
            for (int k = 0; k < 20; k++) begin
                e = z(3'd6);
                e.illegal = 1'b1;
                cyc(iack_bg, dack_bg, e);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        opcode   = 7'd0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        iack_bg  = 1'b0;
        dack_bg  = 1'b0;
        cnt      = '0;
        exp_q    = '0;
        exp_cnt  = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset();

        // R-type with imem_ack held high: states 1,2,3 then FETCH again.
        iack_bg = 1'b1;
        run_instr(OP_R, 0, 0, -1);
        lit("t1_state", {29'd0, state}, 32'd1);
        lit("t1_instret", instret, CNT_EN ? 32'd1 : 32'd0);
        iack_bg = 1'b0;

        // Load, fetch waits 1, dmem_ack after 3 wait cycles.
        dreq_cycles = 0;
        run_instr(OP_L, 1, 3, -1);
        lit("t2_dreq_cycles", dreq_cycles, 32'd4);
        lit("t2_instret", instret, CNT_EN ? 32'd2 : 32'd0);

        // Store with immediate ack; dmem_ack held high elsewhere is ignored.
        dack_bg = 1'b1;
        dreq_cycles = 0;
        run_instr(OP_S, 0, 0, -1);
        lit("t3_dreq_cycles", dreq_cycles, 32'd1);
        run_instr(OP_I, 2, 0, -1);
        dack_bg = 1'b0;

        // Load where imem_ack and dmem_ack coincide in MEM.
        iack_bg = 1'b1;
        run_instr(OP_L, 0, 0, -1);
        lit("t_sim_ack_instret", instret, CNT_EN ? 32'd5 : 32'd0);
        iack_bg = 1'b0;

        // Reset in the middle of a store access, with dmem_ack arriving then.
        run_instr(OP_S, 0, 5, 2);
        dack_bg = 1'b1;
        do_reset();
        dack_bg = 1'b0;
        lit("t5_state_after_rst", {29'd0, state}, 32'd1);
        run_instr(OP_R, 0, 0, -1);
        lit("t5_instret", instret, CNT_EN ? 32'd1 : 32'd0);

`ifdef INSTRET_CNT_EN
        // Counter wrap: preload all-ones, retire one I-type.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        cnt = 32'hFFFF_FFFF;
        run_instr(OP_I, 0, 0, -1);
        lit("t6_wrap", instret, 32'd0);
`else
        run_instr(OP_I, 0, 0, -1);
        lit("t6_tied", instret, 32'd0);
`endif

        // Unsupported opcode traps; imem_ack held high cannot restart fetch.
        iack_bg = 1'b1;
        run_instr(OP_BAD, 0, 0, -1);
        lit("t4_illegal", {31'd0, illegal}, 32'd1);
        iack_bg = 1'b0;
        rst_n = 1'b0;
        #1;
        lit("t4_illegal_rst", {31'd0, illegal}, 32'd0);
        lit("t4_state_rst", {29'd0, state}, 32'd0);
        cnt = '0;
        cyc(1'b0, 1'b0, z(3'd0));
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, z(3'd0));
        run_instr(OP_R, 0, 0, -1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
